jtexterm_shram: RTL and testbench
=================================

Name: jtexterm_shram

Overview:
- Responder for the 8 kB RAM shared between the main CPU and the sound CPU; it serves the sound CPU's ram_addr/ram_din/ram_we/ram_dout port.
- Holds one single-port RAM and arbitrates between the two requesters with a 3-state FSM.
- Returns read data and a per-port ok strobe that the CPUs' wait logic uses.
- Sits at game top level, between the main CPU bus decoder and the sound subsystem.

Parameters:
- AW, 13, address width; RAM depth is 2^AW.
- DW, 8, data width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- main_cs  in  1  main CPU request to the shared RAM.
- main_addr  in  AW  main CPU address.
- main_we  in  1  main CPU write enable, qualified by main_cs.
- main_dout  in  DW  main CPU write data.
- main_din  out  DW  read data to the main CPU.
- main_ok  out  1  main access complete, data valid.
- sub_cs  in  1  sound CPU request; the sound module exports its registered RAM chip select for this.
- sub_addr  in  AW  sound CPU address (ram_addr).
- sub_we  in  1  sound CPU write (ram_we); ignored while sub_cs is low.
- sub_dout  in  DW  sound CPU write data (ram_din).
- sub_din  out  DW  read data to the sound CPU (ram_dout).
- sub_ok  out  1  sound access complete.

Behaviour:
- Reset values: main_din=0, sub_din=0, main_ok=0, sub_ok=0; FSM=IDLE; last_grant=SUB, so main wins the first tie; both pending/done flags cleared. RAM contents are not reset.
- Pending request, per port: cs high, done flag clear. The done flag is set when ok asserts. It clears on the edge after cs goes low, or when the address differs from the latched address.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, one port pending: grant it at the same edge. Latch addr, we and data; go to ACCESS.
- IDLE, both pending: grant the port that is not last_grant (round-robin). Update last_grant.
- ACCESS: RAM cycle. The write is committed at this edge when the latched we=1; otherwise the RAM output register captures the read. Go to RESP.
- RESP: drive the granted port's din from the RAM output (writes return the written data); set its ok=1 and its done flag; go to IDLE.
- Latency: cs sampled high in IDLE at edge 0 → ok high after edge 2. Throughput: one access per 3 clocks.
- Worst-case wait for the losing port: 6 clocks.
- ok clears on the edge after cs falls or the address changes. din holds its last value.
- Each cs assertion writes exactly once, even when cs is held for many cycles.
- cs falls during ACCESS/RESP: the access completes (a write still commits). ok is not asserted; the done flag is not set.
- The two ports never write in the same cycle. On same-address read/write contention, the granted order determines the result.
- rst_n asserted mid-operation: immediate return to reset values. A write still in ACCESS is discarded.
- Address width is used as-is, with no wrap logic. The upper address bits are decoded by the requesters.

Optional Feature:
- Macro JTEXTERM_SHRAM_MAINPRIO_EN.
- Defined: fixed priority; main always wins ties and last_grant is unused. The sound CPU can starve while main_cs requests keep arriving back-to-back.
- Undefined: round-robin as described under Behaviour.

Test Plan:
- Reset, then main write 0x0123←0xA5, then main read 0x0123 → main_ok high 2 clocks after the grant edge; main_din=0xA5; sub_ok stays 0.
- sub_cs and main_cs rise on the same edge after reset → main served first (ok at edge 2); sub served next (sub_ok at edge 5).
- Repeat the same simultaneous requests → sub served first this time (round-robin).
- Sub write 0x1FFF←0x3C with cs held 20 clocks → exactly one RAM write. sub_ok stays high until cs falls, then clears 1 clock later.
- Sub address changes 0x0010→0x0011 while sub_cs stays high → new access; second sub_ok pulse carries the data at 0x0011.
- Main write granted, main_cs dropped in ACCESS → main_ok never asserts; a subsequent read returns the new value.
- rst_n pulsed low during RESP → outputs go to 0 at once and the FSM restarts in IDLE.
- JTEXTERM_SHRAM_MAINPRIO_EN defined, both requesting continuously → main served every grant.

Source files
------------

// File: rtl/jtexterm_shram.sv
// jtexterm_shram: 8 kB RAM shared by the main CPU (port 0) and the sound CPU
// (port 1). One single-port RAM, a 3-state arbiter FSM, and a per-port
// tracker that holds the read data, the ok strobe and the done flag.
// Each cs assertion produces exactly one RAM access. A new access starts
// only after cs drops or the address changes.
// Optional build macro JTEXTERM_SHRAM_MAINPRIO_EN: fixed priority, so main
// always wins a tie. When it is undefined, ties are broken round-robin.

module jtexterm_shram_port #(
  parameter int AW = 13,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  input  logic          grant,
  input  logic          resp,
  input  logic [DW-1:0] rdata,
  output logic          pending,
  output logic [DW-1:0] din,
  output logic          ok
);
  logic [AW-1:0] lat_addr;
  logic          done;

  assign pending = cs & ~done;

  // Latch the granted address. On RESP, return data and raise ok if cs is
  // still held. Otherwise, drop ok/done once cs falls or the address moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_addr <= '0;
      done     <= 1'b0;
      ok       <= 1'b0;
      din      <= '0;
    end else begin
      if (grant) lat_addr <= addr;
      if (resp) begin
        din <= rdata;
        if (cs) begin
          ok   <= 1'b1;
          done <= 1'b1;
        end
      end else if (!cs || addr != lat_addr) begin
        ok   <= 1'b0;
        done <= 1'b0;
      end
    end
  end
endmodule

module jtexterm_shram #(
  parameter int AW = 13,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          main_cs,
  input  logic [AW-1:0] main_addr,
  input  logic          main_we,
  input  logic [DW-1:0] main_dout,
  output logic [DW-1:0] main_din,
  output logic          main_ok,
  input  logic          sub_cs,
  input  logic [AW-1:0] sub_addr,
  input  logic          sub_we,
  input  logic [DW-1:0] sub_dout,
  output logic [DW-1:0] sub_din,
  output logic          sub_ok
);
  localparam int NP = 2;  // 0 = main, 1 = sub

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] data;
  } req_t;

  state_t                   st;
  req_t                     req_q;
  req_t    [NP-1:0]         req_v;
  logic    [NP-1:0]         cs_v, pend, grant, resp, ok_v;
  logic    [NP-1:0][AW-1:0] addr_v;
  logic    [NP-1:0][DW-1:0] din_v;
  logic                     pick, sel;
  logic    [DW-1:0]         rdata;
  logic    [DW-1:0]         mem [0:(1<<AW)-1];
`ifndef JTEXTERM_SHRAM_MAINPRIO_EN
  logic                     last_grant;
`endif

  assign cs_v     = {sub_cs, main_cs};
  assign addr_v   = {sub_addr, main_addr};
  assign req_v[0] = '{addr: main_addr, we: main_we & main_cs, data: main_dout};
  assign req_v[1] = '{addr: sub_addr,  we: sub_we  & sub_cs,  data: sub_dout};

  assign main_din = din_v[0];
  assign main_ok  = ok_v[0];
  assign sub_din  = din_v[1];
  assign sub_ok   = ok_v[1];

  // Choose which pending port wins the next IDLE grant.
  always_comb begin
`ifdef JTEXTERM_SHRAM_MAINPRIO_EN
    pick = ~pend[0];
`else
    pick = (&pend) ? ~last_grant : pend[1];
`endif
  end

  // One-hot grant and response strobes for the port trackers.
  always_comb begin
    grant = '0;
    resp  = '0;
    if (st == IDLE && |pend) grant[pick] = 1'b1;
    if (st == RESP)          resp[sel]   = 1'b1;
  end

  // Arbiter FSM: grant and latch in IDLE, RAM cycle in ACCESS, reply in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st    <= IDLE;
      sel   <= 1'b0;
      req_q <= '0;
`ifndef JTEXTERM_SHRAM_MAINPRIO_EN
      last_grant <= 1'b1;  // sub, so main takes the first tie
`endif
    end else begin
      case (st)
        IDLE: if (|pend) begin
          sel   <= pick;
          req_q <= req_v[pick];
`ifndef JTEXTERM_SHRAM_MAINPRIO_EN
          if (&pend) last_grant <= pick;
`endif
          st    <= ACCESS;
        end
        ACCESS:  st <= RESP;
        RESP:    st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end

  // RAM array with an output register. A write echoes its own data back.
  // The RAM has no reset, and a reset during ACCESS leaves st at IDLE, so
  // a write in flight at that point is dropped.
  always_ff @(posedge clk) begin
    if (st == ACCESS) begin
      if (req_q.we) begin
        mem[req_q.addr] <= req_q.data;
        rdata           <= req_q.data;
      end else begin
        rdata <= mem[req_q.addr];
      end
    end
  end

  // One tracker per requester.
  generate
    for (genvar p = 0; p < NP; p++) begin : g_port
      jtexterm_shram_port #(.AW(AW), .DW(DW)) u_port (
        .clk     (clk),
        .rst_n   (rst_n),
        .cs      (cs_v[p]),
        .addr    (addr_v[p]),
        .grant   (grant[p]),
        .resp    (resp[p]),
        .rdata   (rdata),
        .pending (pend[p]),
        .din     (din_v[p]),
        .ok      (ok_v[p])
      );
    end
  endgenerate
endmodule

// File: tb/tb_jtexterm_shram.sv
// Directed bench for jtexterm_shram. Inputs are driven and outputs sampled
// 1 ns after each rising edge.
module tb_jtexterm_shram;
  localparam int AW = 13;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          main_cs, main_we, sub_cs, sub_we;
  logic [AW-1:0] main_addr, sub_addr;
  logic [DW-1:0] main_dout, sub_dout, main_din, sub_din;
  logic          main_ok, sub_ok;
  int            checks = 0;
  int            errors = 0;
  int            cnt;

  jtexterm_shram #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .main_cs   (main_cs),
    .main_addr (main_addr),
    .main_we   (main_we),
    .main_dout (main_dout),
    .main_din  (main_din),
    .main_ok   (main_ok),
    .sub_cs    (sub_cs),
    .sub_addr  (sub_addr),
    .sub_we    (sub_we),
    .sub_dout  (sub_dout),
    .sub_din   (sub_din),
    .sub_ok    (sub_ok)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Complete main access: ok after 3 edges, then release cs and see ok drop.
  task automatic main_access(input string tag, input logic [AW-1:0] a,
                             input logic we, input logic [DW-1:0] d,
                             input logic [DW-1:0] exp);
    main_cs = 1'b1; main_addr = a; main_we = we; main_dout = d;
    tick(3);
    chk({tag, "_ok"}, main_ok, 1'b1);
    chk({tag, "_din"}, main_din, exp);
    main_cs = 1'b0; main_we = 1'b0;
    tick();
    chk({tag, "_okclr"}, main_ok, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    main_cs = 0; main_we = 0; main_addr = '0; main_dout = '0;
    sub_cs  = 0; sub_we  = 0; sub_addr  = '0; sub_dout  = '0;
    tick(2);
    chk("rst_main_din", main_din, 8'h00);
    chk("rst_sub_din",  sub_din,  8'h00);
    chk("rst_main_ok",  main_ok,  1'b0);
    chk("rst_sub_ok",   sub_ok,   1'b0);
    rst_n = 1'b1;
    tick();

    // Main write 0x0123 <- A5, latency check
    main_cs = 1; main_we = 1; main_addr = 13'h0123; main_dout = 8'hA5;
    tick(2);
    chk("wr_ok_early", main_ok, 1'b0);
    tick();
    chk("wr_ok", main_ok, 1'b1);
    chk("wr_din_echo", main_din, 8'hA5);
    chk("wr_sub_ok", sub_ok, 1'b0);
    main_cs = 0; main_we = 0;
    tick();
    chk("wr_okclr", main_ok, 1'b0);
    main_access("rd0123", 13'h0123, 1'b0, 8'h00, 8'hA5);
    chk("rd0123_sub_ok", sub_ok, 1'b0);

    // Simultaneous requests: main wins the first tie
    main_cs = 1; main_addr = 13'h0123;
    sub_cs = 1; sub_we = 1; sub_addr = 13'h0200; sub_dout = 8'h5A;
    tick(3);
    chk("tie1_main_ok", main_ok, 1'b1);
    chk("tie1_sub_ok0", sub_ok, 1'b0);
    tick(3);
    chk("tie1_sub_ok", sub_ok, 1'b1);
    chk("tie1_sub_din", sub_din, 8'h5A);
    main_cs = 0; sub_cs = 0; sub_we = 0;
    tick();
    chk("tie1_clr", {main_ok, sub_ok}, 2'b00);

    // Second tie: round-robin gives sub the grant (main under fixed priority)
    main_cs = 1; main_addr = 13'h0123;
    sub_cs = 1; sub_addr = 13'h0200;
    tick(3);
`ifdef JTEXTERM_SHRAM_MAINPRIO_EN
    chk("tie2_first", {main_ok, sub_ok}, 2'b10);
    tick(3);
    chk("tie2_second", {main_ok, sub_ok}, 2'b11);
`else
    chk("tie2_first", {main_ok, sub_ok}, 2'b01);
    chk("tie2_sub_din", sub_din, 8'h5A);
    tick(3);
    chk("tie2_second", {main_ok, sub_ok}, 2'b11);
`endif
    chk("tie2_main_din", main_din, 8'hA5);
    main_cs = 0; sub_cs = 0;
    tick();

    // Sub write held 20 clocks: must not rewrite over main's later write
    sub_cs = 1; sub_we = 1; sub_addr = 13'h1FFF; sub_dout = 8'h3C;
    tick(3);
    chk("hold_sub_ok", sub_ok, 1'b1);
    chk("hold_sub_din", sub_din, 8'h3C);
    main_access("hold_mwr", 13'h1FFF, 1'b1, 8'h77, 8'h77);
    main_access("hold_mrd", 13'h1FFF, 1'b0, 8'h00, 8'h77);
    cnt = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (sub_ok) cnt++;
    end
    chk("hold_ok_cycles", cnt, 9);
    sub_cs = 0; sub_we = 0;
    #1;
    chk("hold_ok_pre_edge", sub_ok, 1'b1);
    tick();
    chk("hold_okclr", sub_ok, 1'b0);

    // Sub address change with cs held starts a new access
    main_access("pre10", 13'h0010, 1'b1, 8'h11, 8'h11);
    main_access("pre11", 13'h0011, 1'b1, 8'h22, 8'h22);
    sub_cs = 1; sub_we = 0; sub_addr = 13'h0010;
    tick(3);
    chk("ach_ok1", sub_ok, 1'b1);
    chk("ach_din1", sub_din, 8'h11);
    sub_addr = 13'h0011;
    tick();
    chk("ach_okclr", sub_ok, 1'b0);
    tick(3);
    chk("ach_ok2", sub_ok, 1'b1);
    chk("ach_din2", sub_din, 8'h22);
    sub_cs = 0;
    tick();

    // Main write aborted in ACCESS still commits, without ok
    main_cs = 1; main_we = 1; main_addr = 13'h0300; main_dout = 8'hC3;
    tick();
    main_cs = 0; main_we = 0;
    tick(2);
    chk("abort_ok", main_ok, 1'b0);
    tick();
    chk("abort_ok2", main_ok, 1'b0);
    main_access("abort_rd", 13'h0300, 1'b0, 8'h00, 8'hC3);

    // Reset pulse during RESP
    main_cs = 1; main_addr = 13'h0123;
    tick(2);
    rst_n = 0;
    #1;
    chk("mrst_main_din", main_din, 8'h00);
    chk("mrst_sub_din",  sub_din,  8'h00);
    chk("mrst_ok", {main_ok, sub_ok}, 2'b00);
    #2;
    rst_n = 1;
    tick(3);
    chk("mrst_restart_ok", main_ok, 1'b1);
    chk("mrst_restart_din", main_din, 8'hA5);
    main_cs = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
